// File: rtl/connect4_pkg.sv
// Shared Connect4 display definitions: colour codes, colour-to-RGB mapping
// and the default board geometry used by the renderer and the VGA timing block.
package connect4_pkg;

  typedef enum logic [1:0] {
    WHITE = 2'd0,
    RED   = 2'd1,
    BLUE  = 2'd2,
    BLACK = 2'd3
  } colour_e;

  localparam int DEF_ROWS   = 6;
  localparam int DEF_COLS   = 7;
  localparam int DEF_CELL_W = 88;
  localparam int DEF_LINE_W = 4;
  localparam int DEF_CELL_H = 76;
  localparam int DEF_TOP_Y  = 28;

  // Packed {r, g, b} for a colour code.
  function automatic logic [23:0] colour_rgb(input colour_e c);
    case (c)
      WHITE:   return 24'hFFFFFF;
      RED:     return 24'hFF0000;
      BLUE:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/pixel_locator.sv
// Registered coordinate-to-board mapping: board column/row (with range flags),
// divider flag and cursor-strip flag for one pixel per cycle.
module pixel_locator
  import connect4_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int CELL_W = DEF_CELL_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int CELL_H = DEF_CELL_H,
  parameter int TOP_Y  = DEF_TOP_Y,
  parameter int COL_W  = 3,
  parameter int ROW_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  output logic [COL_W-1:0] col,
  output logic             col_ok,
  output logic [ROW_W-1:0] row,
  output logic             row_ok,
  output logic             divider,
  output logic             strip,
  output logic             vld
);

  localparam int PITCH = CELL_W + LINE_W;

  logic [9:0]       x_div, x_mod, y_off, y_div;
  logic [COL_W-1:0] col_next;
  logic [ROW_W-1:0] row_next;
  logic             col_ok_next, row_ok_next, divider_next, strip_next;

  // Columns count right-to-left and rows bottom-to-top from the x/y division.
  always_comb begin
    x_div        = x / 10'(PITCH);
    x_mod        = x % 10'(PITCH);
    y_off        = y - 10'(TOP_Y);
    y_div        = y_off / 10'(CELL_H);
    col_ok_next  = x_div < 10'(COLS);
    col_next     = COL_W'(COLS - 1) - x_div[COL_W-1:0];
    strip_next   = y < 10'(TOP_Y);
    row_ok_next  = !strip_next && (y_div < 10'(ROWS));
    row_next     = ROW_W'(ROWS - 1) - y_div[ROW_W-1:0];
    divider_next = x_mod >= 10'(CELL_W);
  end

  // Stage 1 register; reset empties the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      col_ok  <= 1'b0;
      row     <= '0;
      row_ok  <= 1'b0;
      divider <= 1'b0;
      strip   <= 1'b0;
      vld     <= 1'b0;
    end else begin
      col     <= col_next;
      col_ok  <= col_ok_next;
      row     <= row_next;
      row_ok  <= row_ok_next;
      divider <= divider_next;
      strip   <= strip_next;
      vld     <= pix_valid;
    end
  end

endmodule

// File: rtl/board_pixel_renderer.sv
// Two-stage Connect4 pixel colour generator: board cells, white dividers,
// cursor strip / winner banner. Optional winning-cell flash is built when
// BOARD_WIN_FLASH_EN is defined.
module board_pixel_renderer
  import connect4_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int CELL_W       = DEF_CELL_W,
  parameter int LINE_W       = DEF_LINE_W,
  parameter int CELL_H       = DEF_CELL_H,
  parameter int TOP_Y        = DEF_TOP_Y,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic                      pix_valid,
  input  logic [9:0]                x,
  input  logic [9:0]                y,
  input  logic [ROWS-1:0][COLS-1:0] tablero,
  input  logic [ROWS-1:0][COLS-1:0] fichas,
  input  logic [ROWS-1:0][COLS-1:0] win_mask,
  input  logic [COLS-1:0]           posicion,
  input  logic                      jugador,
  input  logic                      finJuego,
  output logic                      rgb_valid,
  output logic [7:0]                r,
  output logic [7:0]                g,
  output logic [7:0]                b
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [COL_W-1:0] col_p1;
  logic [ROW_W-1:0] row_p1;
  logic             col_ok_p1, row_ok_p1, divider_p1, strip_p1, vld_p1;

  // ---- stage 1: coordinate mapping ----
  pixel_locator #(
    .ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .LINE_W(LINE_W),
    .CELL_H(CELL_H), .TOP_Y(TOP_Y), .COL_W(COL_W), .ROW_W(ROW_W)
  ) u_locator (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .x(x), .y(y),
    .col(col_p1), .col_ok(col_ok_p1), .row(row_p1), .row_ok(row_ok_p1),
    .divider(divider_p1), .strip(strip_p1), .vld(vld_p1)
  );

`ifdef BOARD_WIN_FLASH_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt;
  logic             flash_phase;

  // Flash timer runs only during game over and is held cleared otherwise.
  always_ff @(posedge clk) begin
    if (rst || !finJuego) begin
      frame_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_flash;
  assign unused_flash = ^{frame_start, win_mask, 32'(BLINK_FRAMES)};
`endif

  logic      occupied, owner, win_flash, cursor_hit;
  colour_e   colour;
  logic [23:0] rgb_next;

  // ---- stage 2: board lookup and colour priority ----
  // Board arrays are only selected through matched in-range indices, so an
  // out-of-board column/row can never address them.
  always_comb begin
    occupied   = 1'b0;
    owner      = 1'b0;
    win_flash  = 1'b0;
    cursor_hit = 1'b0;
    for (int ci = 0; ci < COLS; ci++) begin
      if (col_ok_p1 && col_p1 == COL_W'(ci)) begin
        cursor_hit = posicion[ci];
        for (int ri = 0; ri < ROWS; ri++) begin
          if (row_ok_p1 && row_p1 == ROW_W'(ri)) begin
            occupied = tablero[ri][ci];
            owner    = fichas[ri][ci];
`ifdef BOARD_WIN_FLASH_EN
            win_flash = finJuego && flash_phase && win_mask[ri][ci];
`endif
          end
        end
      end
    end

    colour = BLACK;
    if (!vld_p1) begin
      colour = BLACK;
    end else if (divider_p1) begin
      colour = WHITE;
    end else if (occupied) begin
      if (win_flash)  colour = WHITE;
      else if (owner) colour = RED;
      else            colour = BLUE;
    end else if (strip_p1 && col_ok_p1 && (finJuego || cursor_hit)) begin
      if (jugador) colour = RED;
      else         colour = BLUE;
    end
    rgb_next = colour_rgb(colour);
  end

  // Output register; reset forces black and invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_valid <= 1'b0;
      r         <= 8'h00;
      g         <= 8'h00;
      b         <= 8'h00;
    end else begin
      rgb_valid <= vld_p1;
      r         <= rgb_next[23:16];
      g         <= rgb_next[15:8];
      b         <= rgb_next[7:0];
    end
  end

endmodule

// File: tb/tb_board_pixel_renderer.sv
// Scoreboard bench for board_pixel_renderer (default geometry). Flash checks
// are compiled in when BOARD_WIN_FLASH_EN is defined.
module tb_board_pixel_renderer;

`ifdef BOARD_WIN_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, frame_start, pix_valid, jugador, finJuego;
  logic [9:0]      x, y;
  logic [5:0][6:0] tablero, fichas, win_mask;
  logic [6:0]      posicion;
  logic            rgb_valid;
  logic [7:0]      r, g, b;

  board_pixel_renderer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .x(x), .y(y), .tablero(tablero), .fichas(fichas), .win_mask(win_mask),
    .posicion(posicion), .jugador(jugador), .finJuego(finJuego),
    .rgb_valid(rgb_valid), .r(r), .g(g), .b(b)
  );

  int          checks = 0;
  int          errors = 0;
  logic [24:0] q[$];
  bit          mon_en = 1'b0;
  int          m_cnt = 0;
  logic        m_phase = 1'b0;

  // Reference colour for one pixel, from the board state held by the bench.
  function automatic logic [24:0] model(input int px, input int py, input logic pv);
    int xd, xm, yd, col, row;
    logic cok, rok;
    logic [23:0] c;
    if (!pv) return 25'd0;
    xd  = px / 92;
    xm  = px % 92;
    col = 6 - xd;
    cok = (xd < 7);
    yd  = (py - 28) / 76;
    rok = (py >= 28) && (yd < 6);
    row = 5 - yd;
    c   = 24'h000000;
    if (xm >= 88) c = 24'hFFFFFF;
    else if (cok && rok && tablero[row][col] === 1'b1) begin
      if (FLASH && m_phase && finJuego && win_mask[row][col]) c = 24'hFFFFFF;
      else if (fichas[row][col]) c = 24'hFF0000;
      else c = 24'h0000FF;
    end else if (py < 28 && cok) begin
      if (finJuego || posicion[col]) c = jugador ? 24'hFF0000 : 24'h0000FF;
    end
    return {1'b1, c};
  endfunction

  task automatic drive(input int px, input int py, input logic pv);
    @(posedge clk); #1;
    x = 10'(px); y = 10'(py); pix_valid = pv;
    q.push_back(model(px, py, pv));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 1'b0);
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    drive(0, 0, 1'b0);
    frame_start = 1'b0;
    if (finJuego) begin
      if (m_cnt == 29) begin m_cnt = 0; m_phase = ~m_phase; end
      else m_cnt++;
    end
  endtask

  // Scoreboard: the DUT output two cycles after a pixel matches its entry.
  always @(negedge clk) begin
    if (mon_en && q.size() >= 3) begin
      logic [24:0] e;
      e = q.pop_front();
      checks++;
      if ({rgb_valid, r, g, b} !== e) begin
        errors++;
        $display("FAIL pixel got valid=%0b rgb=%06h expected valid=%0b rgb=%06h",
                 rgb_valid, {r, g, b}, e[24], e[23:0]);
      end
    end
  end

  task automatic test_reset();
    tablero = '0; fichas = '0; tablero[5][6] = 1'b1; fichas[5][6] = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 50, 1'b1);
      @(negedge clk);
      checks++;
      if ({rgb_valid, r, g, b} !== 25'd0) begin
        errors++;
        $display("FAIL reset_state got %07h expected 0000000", {rgb_valid, r, g, b});
      end
    end
    rst = 1'b0;
    idle(2);
    q.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_piece();
    tablero = '0; fichas = '0;
    tablero[5][6] = 1'b1; fichas[5][6] = 1'b1;
    tablero[0][0] = 1'b1; fichas[0][0] = 1'b0;
    tablero[2][3] = 1'b1; fichas[2][3] = 1'b1;
    drive(0, 50, 1'b1);
    drive(0, 50, 1'b0);
    drive(620, 440, 1'b1);
    drive(300, 250, 1'b1);
    drive(87, 103, 1'b1);
    drive(92, 50, 1'b1);
    drive(0, 104, 1'b1);
    idle(2);
  endtask

  task automatic test_divider();
    tablero = '1;
    for (int i = 0; i < 6; i++) fichas[i] = 7'($urandom);
    foreach (q[i]) ; // no-op keeps queue untouched
    drive(90, 0, 1'b1);   drive(90, 10, 1'b1);  drive(90, 50, 1'b1);
    drive(90, 300, 1'b1); drive(90, 480, 1'b1);
    drive(644, 50, 1'b1); drive(644, 10, 1'b1); drive(643, 50, 1'b1);
    drive(5, 483, 1'b1);  drive(5, 484, 1'b1);  drive(5, 27, 1'b1);
    for (int xx = 0; xx < 732; xx += 13) drive(xx, 100, 1'b1);
    idle(2);
  endtask

  task automatic test_cursor();
    tablero = '0; posicion = 7'b0001000; jugador = 1'b0; finJuego = 1'b0;
    drive(276, 10, 1'b1); drive(300, 10, 1'b1); drive(363, 10, 1'b1);
    drive(0, 10, 1'b1);   drive(364, 10, 1'b1); drive(275, 10, 1'b1);
    drive(368, 10, 1'b1); drive(200, 10, 1'b1); drive(300, 28, 1'b1);
    idle(2);
  endtask

  task automatic test_banner();
    jugador = 1'b1; finJuego = 1'b1; posicion = 7'b0000001;
    for (int xx = 0; xx < 644; xx += 5) drive(xx, 10, 1'b1);
    drive(10, 27, 1'b1); drive(10, 28, 1'b1); drive(700, 10, 1'b1);
    idle(2);
    finJuego = 1'b0; m_cnt = 0; m_phase = 1'b0;
    idle(2);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      tablero[i] = 7'($urandom); fichas[i] = 7'($urandom);
    end
    posicion = 7'(1 << $urandom_range(0, 6));
    jugador = 1'($urandom);
    for (int i = 0; i < 200; i++)
      drive($urandom_range(0, 731), $urandom_range(0, 520), 1'($urandom_range(0, 3) != 0));
    idle(2);
  endtask

`ifdef BOARD_WIN_FLASH_EN
  task automatic test_flash();
    tablero = '0; fichas = '0; win_mask = '0;
    tablero[5][6] = 1'b1; fichas[5][6] = 1'b1; win_mask[5][6] = 1'b1;
    tablero[0][0] = 1'b1;
    jugador = 1'b1; finJuego = 1'b1;
    idle(2);
    drive(0, 50, 1'b1); drive(620, 440, 1'b1); idle(2);
    repeat (30) pulse();
    drive(0, 50, 1'b1); drive(620, 440, 1'b1); idle(2);
    repeat (30) pulse();
    drive(0, 50, 1'b1); idle(2);
    repeat (30) pulse();
    drive(0, 50, 1'b1); idle(2);
    finJuego = 1'b0; m_cnt = 0; m_phase = 1'b0;
    idle(2);
    drive(0, 50, 1'b1); idle(2);
  endtask
`endif

  task automatic test_reset_midstream();
    tablero = '0; fichas = '0; win_mask = '0;
    tablero[5][6] = 1'b1; fichas[5][6] = 1'b1; win_mask[5][6] = 1'b1;
    jugador = 1'b1; finJuego = 1'b1;
    repeat (10) pulse();
    mon_en = 1'b0;
    repeat (3) drive(0, 50, 1'b1);
    rst = 1'b1; m_cnt = 0; m_phase = 1'b0;
    drive(0, 50, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rgb_valid, r, g, b} !== 25'd0) begin
      errors++;
      $display("FAIL rst_out1 got %07h expected 0000000", {rgb_valid, r, g, b});
    end
    drive(0, 50, 1'b1);
    @(negedge clk);
    checks++;
    if ({rgb_valid, r, g, b} !== 25'd0) begin
      errors++;
      $display("FAIL rst_out2 got %07h expected 0000000", {rgb_valid, r, g, b});
    end
    drive(0, 50, 1'b1);
    @(negedge clk);
    checks++;
    if ({rgb_valid, r, g, b} !== 25'h1FF0000) begin
      errors++;
      $display("FAIL rst_resume got %07h expected 1ff0000", {rgb_valid, r, g, b});
    end
    idle(2);
    q.delete();
    mon_en = 1'b1;
    idle(2);
    repeat (29) pulse();
    drive(0, 50, 1'b1); idle(2);
    pulse();
    drive(0, 50, 1'b1); idle(2);
    finJuego = 1'b0; m_cnt = 0; m_phase = 1'b0;
    idle(3);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; x = '0; y = '0;
    tablero = '0; fichas = '0; win_mask = '0; posicion = '0;
    jugador = 1'b0; finJuego = 1'b0;
    test_reset();
    test_piece();
    test_divider();
    test_cursor();
    test_banner();
    test_back_to_back();
`ifdef BOARD_WIN_FLASH_EN
    test_flash();
`endif
    test_reset_midstream();
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
